// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file writeback arbiter with load scoreboard (optional REGFILE_WB_BYPASS_EN)
module regfile_wb_arbiter #(
  parameter bit LD_PRIORITY = 1'b1,
  parameter int WAIT_MAX    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic [31:0] busy,
  output logic        write,
  output logic [4:0]  rd,
  output logic [31:0] reg_write,
  output logic        fwd1_valid,
  output logic        fwd2_valid,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  logic [3:0]  wait_cnt;
  logic        alu_elig;
  logic        ld_elig;
  logic        starved;
  logic        alu_win;
  logic        ld_win;
  logic        lo_valid;
  logic        lo_win;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;
  logic [31:0] busy_next;

  // An ALU write to a register still owed a load would overtake that load.
  assign alu_elig = alu_valid && !busy[alu_rd];
  assign ld_elig  = ld_valid;
  assign starved  = (wait_cnt == WAIT_LIM);

  always_comb begin
    alu_win = 1'b0;
    ld_win  = 1'b0;
    if (alu_elig && ld_elig) begin
      if (LD_PRIORITY ^ starved) ld_win = 1'b1;
      else                       alu_win = 1'b1;
    end else if (ld_elig) begin
      ld_win = 1'b1;
    end else if (alu_elig) begin
      alu_win = 1'b1;
    end
  end

  assign alu_ready  = alu_win;
  assign ld_ready   = ld_win;
  assign lo_valid   = LD_PRIORITY ? alu_valid : ld_valid;
  assign lo_win     = LD_PRIORITY ? alu_win : ld_win;
  assign grant_rd   = ld_win ? ld_rd : alu_rd;
  assign grant_data = ld_win ? ld_data : alu_data;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_next = busy;
    if (ld_win) busy_next[ld_rd] = 1'b0;
    if (ld_issue && ld_issue_rd != 5'd0) busy_next[ld_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 4'd0;
      busy      <= 32'd0;
      write     <= 1'b0;
      rd        <= 5'd0;
      reg_write <= 32'd0;
    end else begin
      busy <= busy_next;
      if (lo_win || !lo_valid) wait_cnt <= 4'd0;
      else if (alu_elig && ld_elig && !starved) wait_cnt <= wait_cnt + 4'd1;
      write <= (alu_win || ld_win) && (grant_rd != 5'd0);
      if ((alu_win || ld_win) && grant_rd != 5'd0) begin
        rd        <= grant_rd;
        reg_write <= grant_data;
      end
    end
  end

  assign stall = busy[rs1] | busy[rs2];

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd1_valid = write && (rd != 5'd0) && (rd == rs1);
  assign fwd2_valid = write && (rd != 5'd0) && (rd == rs2);
  assign fwd1_data  = fwd1_valid ? reg_write : 32'd0;
  assign fwd2_data  = fwd2_valid ? reg_write : 32'd0;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = 32'd0;
  assign fwd2_data  = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_issue, ld_valid;
  logic [4:0]  alu_rd, ld_issue_rd, ld_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, stall, write;
  logic [31:0] busy, reg_write;
  logic [4:0]  rd;
  logic        fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.LD_PRIORITY(1'b1), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy),
    .write(write), .rd(rd), .reg_write(reg_write),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; combinational checks run 2 units later.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    idle_inputs();
    step();
    step();
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %0h want 0", write); end
    n_cmp++; if (rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd: got %0d want 0", rd); end
    n_cmp++; if (reg_write !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %08h want 0", reg_write); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("FAIL reset_busy: got %08h want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0h want 0", stall); end
    rst = 1;
    step();
  endtask

  task automatic test_alu_write;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #2;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready: got %0h want 1", alu_ready); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL alu_ld_ready: got %0h want 0", ld_ready); end
    step();
    alu_valid = 0;
    n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL alu_write_en: got %0h want 1", write); end
    n_cmp++; if (rd !== 5'd5) begin n_bad++; $display("FAIL alu_rd: got %0d want 5", rd); end
    n_cmp++; if (reg_write !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_data: got %08h want deadbeef", reg_write); end
    step();
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL alu_write_once: got %0h want 0", write); end
  endtask

  task automatic test_load_scoreboard;
    ld_issue = 1; ld_issue_rd = 7; rs1 = 7;
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ld_stall_early: got %0h want 0", stall); end
    step();
    ld_issue = 0;
    n_cmp++; if (busy !== 32'h0000_0080) begin n_bad++; $display("FAIL ld_busy_set: got %08h want 00000080", busy); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ld_stall: got %0h want 1", stall); end
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    #2;
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready: got %0h want 1", ld_ready); end
    step();
    ld_valid = 0;
    #1;
    n_cmp++; if (write !== 1'b1 || rd !== 5'd7) begin n_bad++; $display("FAIL ld_write: got write=%0h rd=%0d want 1/7", write, rd); end
    n_cmp++; if (reg_write !== 32'h1234) begin n_bad++; $display("FAIL ld_data: got %08h want 00001234", reg_write); end
    n_cmp++; if (busy !== 32'd0 || stall !== 1'b0) begin n_bad++; $display("FAIL ld_clear: got busy=%08h stall=%0h want 0/0", busy, stall); end
`ifdef REGFILE_WB_BYPASS_EN
    n_cmp++; if (fwd1_valid !== 1'b1 || fwd1_data !== 32'h1234) begin n_bad++; $display("FAIL ld_fwd1: got %0h/%08h want 1/00001234", fwd1_valid, fwd1_data); end
`else
    n_cmp++; if (fwd1_valid !== 1'b0 || fwd1_data !== 32'd0) begin n_bad++; $display("FAIL ld_fwd1_tied: got %0h/%08h want 0/0", fwd1_valid, fwd1_data); end
`endif
    n_cmp++; if (fwd2_valid !== 1'b0) begin n_bad++; $display("FAIL ld_fwd2: got %0h want 0", fwd2_valid); end
    rs1 = 0;
    step();
  endtask

  task automatic test_starvation;
    logic [9:0] exp_ld;
    exp_ld = 10'b01111_01111;
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA;
    ld_valid = 1; ld_rd = 11; ld_data = 32'hB;
    for (int i = 0; i < 10; i++) begin
      #2;
      n_cmp++;
      if (ld_ready !== exp_ld[i] || alu_ready !== !exp_ld[i]) begin
        n_bad++;
        $display("FAIL starve_grant[%0d]: got ld=%0h alu=%0h want ld=%0h", i, ld_ready, alu_ready, exp_ld[i]);
      end
      step();
      n_cmp++;
      if (write !== 1'b1 || rd !== (exp_ld[i] ? 5'd11 : 5'd10)) begin
        n_bad++;
        $display("FAIL starve_write[%0d]: got write=%0h rd=%0d want 1/%0d", i, write, rd, exp_ld[i] ? 11 : 10);
      end
    end
    alu_valid = 0; ld_valid = 0;
    step();
  endtask

  task automatic test_waw;
    ld_issue = 1; ld_issue_rd = 9;
    step();
    ld_issue = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'hAAAA;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL waw_hold[%0d]: got %0h want 0", i, alu_ready); end
      step();
    end
    ld_valid = 1; ld_rd = 9; ld_data = 32'h5555;
    #2;
    n_cmp++; if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin n_bad++; $display("FAIL waw_ld_first: got ld=%0h alu=%0h want 1/0", ld_ready, alu_ready); end
    step();
    ld_valid = 0;
    #1;
    n_cmp++; if (write !== 1'b1 || rd !== 5'd9 || reg_write !== 32'h5555) begin n_bad++; $display("FAIL waw_ld_write: got %0h/%0d/%08h want 1/9/00005555", write, rd, reg_write); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL waw_alu_after: got %0h want 1", alu_ready); end
    step();
    alu_valid = 0;
    n_cmp++; if (write !== 1'b1 || rd !== 5'd9 || reg_write !== 32'hAAAA) begin n_bad++; $display("FAIL waw_alu_write: got %0h/%0d/%08h want 1/9/0000aaaa", write, rd, reg_write); end
    step();
  endtask

  task automatic test_x0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    ld_issue = 1; ld_issue_rd = 0;
    #2;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %0h want 1", alu_ready); end
    step();
    alu_valid = 0; ld_issue = 0;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL x0_write: got %0h want 0", write); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("FAIL x0_busy: got %08h want 0", busy); end
    step();
  endtask

  task automatic test_same_cycle_and_async_reset;
    ld_issue = 1; ld_issue_rd = 3;
    step();
    ld_valid = 1; ld_rd = 3; ld_data = 32'h5;
    #2;
    n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL same_ready: got %0h want 1", ld_ready); end
    step();
    ld_issue = 0; ld_valid = 0;
    rs1 = 3;
    #1;
    n_cmp++; if (busy !== 32'h0000_0008 || stall !== 1'b1) begin n_bad++; $display("FAIL same_set_wins: got busy=%08h stall=%0h want 00000008/1", busy, stall); end
    n_cmp++; if (write !== 1'b1 || rd !== 5'd3) begin n_bad++; $display("FAIL same_write: got %0h/%0d want 1/3", write, rd); end
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    #1;
    rst = 0;
    #1;
    n_cmp++; if (write !== 1'b0 || rd !== 5'd0) begin n_bad++; $display("FAIL async_rst_write: got %0h/%0d want 0/0", write, rd); end
    n_cmp++; if (busy !== 32'd0 || stall !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy: got %08h/%0h want 0/0", busy, stall); end
    idle_inputs();
    step();
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL async_rst_drop: got %0h want 0", write); end
    rst = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_scoreboard();
    test_starvation();
    test_waw();
    test_x0();
    test_same_cycle_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
